alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the registered four-unit ALU (arith/logic/CMP/shift).
- Accepts a three-word command frame (opcode, A, B) over a valid/ready stream and drives ALU_FUN/A/B.
- Selects the result of the addressed unit and returns the 2*width result as two width-bit words over a valid/ready stream.
- Sits between the command link (UART/SYS_CTRL side) and the ALU top.

Parameters:
- width, 8, operand width; command and response word width.
- TIMEOUT, 4, number of WAIT cycles allowed for the selected unit flag before an error response (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Cmd_Data  in  width  command word.
- Cmd_Valid  in  1  Cmd_Data is valid.
- Cmd_Ready  out  1  sequencer accepts a word this cycle.
- ALU_A  out  width  operand A to the ALU.
- ALU_B  out  width  operand B to the ALU.
- ALU_FUN  out  4  ALU function code.
- Arith_Out  in  2*width  ALU arithmetic result.
- Arith_Flag  in  1  arithmetic result valid.
- Logic_Out  in  width  ALU logic result.
- Logic_Flag  in  1  logic result valid.
- CMP_Out  in  width  ALU compare result.
- CMP_Flag  in  1  compare result valid.
- SHIFT_Out  in  width  ALU shift result.
- SHIFT_Flag  in  1  shift result valid.
- Res_Data  out  width  response word.
- Res_Valid  out  1  Res_Data is valid.
- Res_Ready  in  1  downstream accepts the response word.
- Res_Err  out  1  the current response is a timeout error.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - ALU_A, ALU_B, ALU_FUN, result register, timeout counter = 0.
  - Res_Valid=0, Res_Err=0, Res_Data=0.
  - Cmd_Ready is a decode of state, so it reads 1 after reset.
  - Reset mid-frame or mid-response aborts everything. No partial response is emitted.
- Handshakes:
  - A word transfers on a rising edge where Cmd_Valid&Cmd_Ready (command side) or Res_Valid&Res_Ready (response side).
  - Cmd_Ready=1 only in IDLE, GET_A and GET_B.
  - Res_Valid=1 only in SEND_LO and SEND_HI.
  - Res_Data and Res_Err stay stable while Res_Valid=1 and Res_Ready=0.
- FSM:
  - IDLE: on accept, ALU_FUN<=Cmd_Data[3:0]; upper bits are ignored. Go to GET_A.
  - GET_A: on accept, ALU_A<=Cmd_Data. Go to GET_B.
  - GET_B: on accept, ALU_B<=Cmd_Data. Go to ISSUE.
  - ISSUE: one cycle, no handshake. Operands are stable, and the ALU registers the new result at the end of this cycle. Clear the counter. Go to WAIT.
  - WAIT: select unit by ALU_FUN[3:2]: 00 arith, 01 logic, 10 CMP, 11 shift.
    - If the selected flag=1, capture the result. Arith is taken as the full 2*width bits; the others are zero-extended to 2*width. Set Res_Err<=0 and go to SEND_LO.
    - Else if counter==TIMEOUT-1, set result<=all ones and Res_Err<=1, then go to SEND_LO.
    - Else counter+1.
    - Flags of non-selected units are ignored.
  - SEND_LO: Res_Data=result[width-1:0]. On accept, go to SEND_HI.
  - SEND_HI: Res_Data=result[2*width-1:width]. On accept, clear Res_Err and go to IDLE.
- Latency:
  - From the B-word accept edge to Res_Valid rising is 3 cycles when the flag is present on the first WAIT cycle: ISSUE, WAIT, then SEND_LO.
  - Worst case is 2+TIMEOUT cycles.
- Other rules:
  - ALU_A/B/FUN hold their values from capture until the next frame's corresponding accept, through SEND and IDLE.
  - Cmd_Valid asserted while not ready is ignored. No word is consumed and none is dropped.
  - Back-to-back frames: the opcode of the next frame may be accepted in the cycle after the SEND_HI accept (IDLE).
  - Res_Ready held high gives one word per cycle.

Test Plan:
1. Reset, then frame 0x02,0x0F,0x10 (multiply) with Res_Ready=1 -> Res_Valid rises 3 cycles after the B accept; words 0xF0 then 0x00, Res_Err=0.
2. Frame 0x01,0x05,0x07 (subtract) -> words 0xFE, 0xFF (16-bit two's-complement result from the ALU), Res_Err=0.
3. Frame 0x04,0xCC,0xAA (logic AND) with Res_Ready low for 5 cycles -> Res_Valid held, Res_Data stable at 0x88 for all 5 cycles; then 0x88, 0x00.
4. Frame 0x0C,0x81,0x00 (shift) with a stub ALU holding SHIFT_Flag=0 -> after TIMEOUT=4 WAIT cycles: words 0xFF, 0xFF with Res_Err=1 on both; Res_Err=0 after SEND_HI accept.
5. Assert RST asynchronously after the A word, mid-GET_B -> immediately ALU_A=0, Res_Valid=0, Cmd_Ready=1. A fresh frame 0x08,0x03,0x03 (CMP equal) -> result zero-extended CMP_Out, high word 0x00.
6. Cmd_Valid toggling with random gaps over 3 consecutive frames -> exactly 6 response words, in order, with no lost or duplicated command words.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the registered four-unit ALU: collects an
// (opcode, A, B) frame, waits for the addressed unit's flag, returns the result.
module alu_cmd_sequencer #(
  parameter int width   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [width-1:0]   Cmd_Data,
  input  logic               Cmd_Valid,
  output logic               Cmd_Ready,
  output logic [width-1:0]   ALU_A,
  output logic [width-1:0]   ALU_B,
  output logic [3:0]         ALU_FUN,
  input  logic [2*width-1:0] Arith_Out,
  input  logic               Arith_Flag,
  input  logic [width-1:0]   Logic_Out,
  input  logic               Logic_Flag,
  input  logic [width-1:0]   CMP_Out,
  input  logic               CMP_Flag,
  input  logic [width-1:0]   SHIFT_Out,
  input  logic               SHIFT_Flag,
  output logic [width-1:0]   Res_Data,
  output logic               Res_Valid,
  input  logic               Res_Ready,
  output logic               Res_Err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_A   = 3'd1;
  localparam logic [2:0] GET_B   = 3'd2;
  localparam logic [2:0] ISSUE   = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] SEND_LO = 3'd5;
  localparam logic [2:0] SEND_HI = 3'd6;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  logic [2:0]         state;
  logic [2*width-1:0] result;
  logic [3:0]         tmo_cnt;
  logic               cmd_fire;
  logic               res_fire;
  logic               sel_flag;
  logic [2*width-1:0] sel_out;

  assign Cmd_Ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign Res_Valid = (state == SEND_LO) || (state == SEND_HI);
  assign cmd_fire  = Cmd_Valid && Cmd_Ready;
  assign res_fire  = Res_Valid && Res_Ready;

  // Only the unit addressed by ALU_FUN[3:2] is looked at; other flags are ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    sel_flag = 1'b0;
    sel_out  = '0;
    case (ALU_FUN[3:2])
      2'b00: begin sel_flag = Arith_Flag; sel_out = Arith_Out;                  end
      2'b01: begin sel_flag = Logic_Flag; sel_out = {{width{1'b0}}, Logic_Out}; end
      2'b10: begin sel_flag = CMP_Flag;   sel_out = {{width{1'b0}}, CMP_Out};   end
      default: begin sel_flag = SHIFT_Flag; sel_out = {{width{1'b0}}, SHIFT_Out}; end
    endcase
  end

  always_comb begin
    Res_Data = '0;
    if (state == SEND_LO)      Res_Data = result[width-1:0];
    else if (state == SEND_HI) Res_Data = result[2*width-1:width];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= '0;
      result  <= '0;
      tmo_cnt <= '0;
      Res_Err <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state)
        IDLE: if (cmd_fire) begin
          ALU_FUN <= Cmd_Data[3:0];
          state   <= GET_A;
        end
        GET_A: if (cmd_fire) begin
          ALU_A <= Cmd_Data;
          state <= GET_B;
        end
        GET_B: if (cmd_fire) begin
          ALU_B <= Cmd_Data;
          state <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (sel_flag) begin
            result  <= sel_out;
            Res_Err <= 1'b0;
            state   <= SEND_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            result  <= '1;
            Res_Err <= 1'b1;
            state   <= SEND_LO;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        SEND_LO: if (res_fire) state <= SEND_HI;
        SEND_HI: if (res_fire) begin
          Res_Err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU stub with adjustable flag delay,
// a vector table, directed multi-cycle sequences and randomized frames.
module tb_alu_cmd_sequencer;

  localparam int W   = 8;
  localparam int TMO = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] Cmd_Data;
  logic         Cmd_Valid;
  logic         Cmd_Ready;
  logic [W-1:0] ALU_A, ALU_B;
  logic [3:0]   ALU_FUN;
  logic [2*W-1:0] Arith_Out;
  logic         Arith_Flag;
  logic [W-1:0] Logic_Out, CMP_Out, SHIFT_Out;
  logic         Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic [W-1:0] Res_Data;
  logic         Res_Valid;
  logic         Res_Ready;
  logic         Res_Err;

  alu_cmd_sequencer #(.width(W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_Data(Cmd_Data), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .Arith_Out(Arith_Out), .Arith_Flag(Arith_Flag),
    .Logic_Out(Logic_Out), .Logic_Flag(Logic_Flag),
    .CMP_Out(CMP_Out), .CMP_Flag(CMP_Flag),
    .SHIFT_Out(SHIFT_Out), .SHIFT_Flag(SHIFT_Flag),
    .Res_Data(Res_Data), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready),
    .Res_Err(Res_Err)
  );

  always #5 CLK = ~CLK;

  // ALU behaviour: arith add/sub/mul/div, logic and/or/nand/nor,
  // CMP eq->1 / gt->2 / lt->3 / none->0, shift A>>1, A<<1, B>>1, B<<1.
  function automatic logic [15:0] alu_math(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  r8;
    r  = '0;
    r8 = '0;
    case (fun)
      4'h0: r  = 16'(a) + 16'(b);
      4'h1: r  = 16'(a) - 16'(b);
      4'h2: r  = 16'(a) * 16'(b);
      4'h3: r  = (b == 8'd0) ? 16'h0000 : 16'(a / b);
      4'h4: r8 = a & b;
      4'h5: r8 = a | b;
      4'h6: r8 = ~(a & b);
      4'h7: r8 = ~(a | b);
      4'h8: r8 = (a == b) ? 8'd1 : 8'd0;
      4'h9: r8 = (a > b)  ? 8'd2 : 8'd0;
      4'hA: r8 = (a < b)  ? 8'd3 : 8'd0;
      4'hB: r8 = 8'd0;
      4'hC: r8 = a >> 1;
      4'hD: r8 = a << 1;
      4'hE: r8 = b >> 1;
      default: r8 = b << 1;
    endcase
    if (fun[3:2] != 2'b00) r = {8'h00, r8};
    return r;
  endfunction

  // Expected {Res_Err, 16-bit result} for one frame.
  function automatic logic [16:0] ref_resp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic dead);
    if (dead) return {1'b1, 16'hFFFF};
    return {1'b0, alu_math(op[3:0], a, b)};
  endfunction

  // ALU stub: registered outputs; the selected flag rises once inputs have been
  // stable for alu_delay edges, never when alu_dead; other flags carry noise.
  int   alu_delay = 0;
  bit   alu_dead  = 1'b0;
  bit   noise_en  = 1'b0;
  bit [19:0] prev_in;
  int   stable_cnt;

  always @(posedge CLK) begin
    logic [19:0] cur;
    int          nxt;
    logic [15:0] v;
    logic [3:0]  fl;
    cur = {ALU_FUN, ALU_A, ALU_B};
    nxt = (cur != prev_in) ? 0 : ((stable_cnt >= 255) ? 255 : stable_cnt + 1);
    prev_in    <= cur;
    stable_cnt <= nxt;
    Arith_Out  <= alu_math({2'b00, ALU_FUN[1:0]}, ALU_A, ALU_B);
    v = alu_math({2'b01, ALU_FUN[1:0]}, ALU_A, ALU_B); Logic_Out <= v[7:0];
    v = alu_math({2'b10, ALU_FUN[1:0]}, ALU_A, ALU_B); CMP_Out   <= v[7:0];
    v = alu_math({2'b11, ALU_FUN[1:0]}, ALU_A, ALU_B); SHIFT_Out <= v[7:0];
    for (int u = 0; u < 4; u++) begin
      if (ALU_FUN[3:2] == 2'(u)) fl[u] = !alu_dead && (nxt >= alu_delay);
      else                       fl[u] = noise_en && ($urandom_range(0, 1) == 1);
    end
    Arith_Flag <= fl[0];
    Logic_Flag <= fl[1];
    CMP_Flag   <= fl[2];
    SHIFT_Flag <= fl[3];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds the word on Cmd_Data until it is accepted; returns 1 ns after the accept edge.
  task automatic send_word(input logic [7:0] w);
    int   n;
    logic rdy;
    n = 0;
    Cmd_Data  = w;
    Cmd_Valid = 1'b1;
    do begin
      @(negedge CLK);
      rdy = Cmd_Ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    Cmd_Valid = 1'b0;
    check("cmd_accept", 32'(rdy), 32'd1);
  endtask

  task automatic recv_word(output logic [7:0] d, output logic e);
    int   n;
    logic v;
    n = 0;
    Res_Ready = 1'b1;
    do begin
      @(negedge CLK);
      v = Res_Valid;
      d = Res_Data;
      e = Res_Err;
      tick();
      n++;
    end while (!v && n < 200);
    check("res_valid_seen", 32'(v), 32'd1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [16:0] exp, input int stall);
    logic [7:0] d;
    logic       e;
    Res_Ready = 1'b0;
    send_word(op);
    send_word(a);
    send_word(b);
    repeat (stall) tick();
    recv_word(d, e);
    check({name, "_lo"},    32'(d), 32'(exp[7:0]));
    check({name, "_err_lo"}, 32'(e), 32'(exp[16]));
    recv_word(d, e);
    check({name, "_hi"},    32'(d), 32'(exp[15:8]));
    check({name, "_err_hi"}, 32'(e), 32'(exp[16]));
    check({name, "_err_clr"}, 32'(Res_Err), 32'd0);
    check({name, "_idle"},    32'(Res_Valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        dead;
    logic [15:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0]  d;
    logic        e;
    logic [16:0] exp;
    logic [7:0]  f6_words[9];
    logic [16:0] f6_exp[$];
    logic [8:0]  f6_got[$];
    int          n;

    vecs[0]  = '{8'h00, 8'hFF, 8'h01, 1'b0, 16'h0100, 1'b0};
    vecs[1]  = '{8'h01, 8'h05, 8'h07, 1'b0, 16'hFFFE, 1'b0};
    vecs[2]  = '{8'h02, 8'h0F, 8'h10, 1'b0, 16'h00F0, 1'b0};
    vecs[3]  = '{8'h03, 8'h64, 8'h07, 1'b0, 16'h000E, 1'b0};
    vecs[4]  = '{8'h05, 8'hCC, 8'hAA, 1'b0, 16'h00EE, 1'b0};
    vecs[5]  = '{8'h06, 8'hCC, 8'hAA, 1'b0, 16'h0077, 1'b0};
    vecs[6]  = '{8'h07, 8'hCC, 8'hAA, 1'b0, 16'h0011, 1'b0};
    vecs[7]  = '{8'h09, 8'h05, 8'h03, 1'b0, 16'h0002, 1'b0};
    vecs[8]  = '{8'h0A, 8'h03, 8'h05, 1'b0, 16'h0003, 1'b0};
    vecs[9]  = '{8'h0B, 8'h03, 8'h05, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{8'h0D, 8'h81, 8'h00, 1'b0, 16'h0002, 1'b0};
    vecs[11] = '{8'h0E, 8'h00, 8'h81, 1'b0, 16'h0040, 1'b0};
    vecs[12] = '{8'hF2, 8'h03, 8'h04, 1'b0, 16'h000C, 1'b0};
    vecs[13] = '{8'h0F, 8'h00, 8'h81, 1'b0, 16'h0002, 1'b0};
    vecs[14] = '{8'h03, 8'h12, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[15] = '{8'h00, 8'h01, 8'h01, 1'b1, 16'hFFFF, 1'b1};

    RST = 1'b1; Cmd_Data = '0; Cmd_Valid = 1'b0; Res_Ready = 1'b0;
    @(negedge CLK);
    check("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    check("rst_res_valid", 32'(Res_Valid), 32'd0);
    check("rst_res_data",  32'(Res_Data),  32'd0);
    check("rst_res_err",   32'(Res_Err),   32'd0);
    check("rst_alu_ops",   32'({ALU_FUN, ALU_A, ALU_B}), 32'd0);
    RST = 1'b0;
    tick();

    // Multiply with Res_Ready high: Res_Valid appears in the third cycle after the B accept.
    Res_Ready = 1'b1;
    send_word(8'h02); send_word(8'h0F); send_word(8'h10);
    check("t1_ops", 32'({ALU_FUN, ALU_A, ALU_B}), 32'h20F10);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      check($sformatf("t1_lat_c%0d", c), 32'(Res_Valid), 32'(c == 3));
      if (c < 3) tick();
    end
    check("t1_lo", 32'(Res_Data), 32'hF0);
    check("t1_err_lo", 32'(Res_Err), 32'd0);
    tick();
    recv_word(d, e);
    check("t1_hi", 32'(d), 32'h00);
    check("t1_err_hi", 32'(e), 32'd0);

    // Logic AND with the response held off for five cycles.
    Res_Ready = 1'b0;
    send_word(8'h04); send_word(8'hCC); send_word(8'hAA);
    n = 0;
    while (!Res_Valid && n < 50) begin tick(); n++; end
    check("t3_valid", 32'(Res_Valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check($sformatf("t3_hold_v%0d", c), 32'(Res_Valid), 32'd1);
      check($sformatf("t3_hold_d%0d", c), 32'(Res_Data), 32'h88);
      tick();
    end
    recv_word(d, e);
    check("t3_lo", 32'(d), 32'h88);
    recv_word(d, e);
    check("t3_hi", 32'(d), 32'h00);

    for (int i = 0; i < 16; i++) begin
      alu_dead = vecs[i].dead;
      run_frame($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                {vecs[i].exp_err, vecs[i].exp}, i % 3);
    end
    alu_dead = 1'b0;

    // Shift with a silent unit: error response after TIMEOUT WAIT cycles.
    alu_dead = 1'b1;
    Res_Ready = 1'b1;
    send_word(8'h0C); send_word(8'h81); send_word(8'h00);
    for (int c = 1; c <= 2 + TMO; c++) begin
      @(negedge CLK);
      check($sformatf("t4_lat_c%0d", c), 32'(Res_Valid), 32'(c == 2 + TMO));
      if (c < 2 + TMO) tick();
    end
    check("t4_lo", 32'(Res_Data), 32'hFF);
    check("t4_err_lo", 32'(Res_Err), 32'd1);
    tick();
    recv_word(d, e);
    check("t4_hi", 32'(d), 32'hFF);
    check("t4_err_hi", 32'(e), 32'd1);
    check("t4_err_clr", 32'(Res_Err), 32'd0);
    alu_dead = 1'b0;

    // Flag arriving on the last allowed WAIT cycle is still a good result.
    alu_delay = TMO - 1;
    send_word(8'h00); send_word(8'h11); send_word(8'h22);
    for (int c = 1; c <= 2 + TMO; c++) begin
      @(negedge CLK);
      check($sformatf("tlate_lat_c%0d", c), 32'(Res_Valid), 32'(c == 2 + TMO));
      if (c < 2 + TMO) tick();
    end
    check("tlate_lo", 32'(Res_Data), 32'h33);
    check("tlate_err", 32'(Res_Err), 32'd0);
    tick();
    recv_word(d, e);
    check("tlate_hi", 32'(d), 32'h00);
    alu_delay = 0;

    // Asynchronous reset in GET_B aborts the frame.
    send_word(8'h08); send_word(8'h55);
    #2 RST = 1'b1;
    #1;
    check("t5_alu_a",     32'(ALU_A),     32'd0);
    check("t5_alu_fun",   32'(ALU_FUN),   32'd0);
    check("t5_res_valid", 32'(Res_Valid), 32'd0);
    check("t5_cmd_ready", 32'(Cmd_Ready), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    run_frame("t5_cmp", 8'h08, 8'h03, 8'h03, 17'h00001, 0);

    // Three frames with random gaps on both streams.
    noise_en  = 1'b1;
    alu_delay = $urandom_range(0, TMO - 1);
    for (int f = 0; f < 3; f++) begin
      f6_words[f*3]   = 8'($urandom);
      f6_words[f*3+1] = 8'($urandom);
      f6_words[f*3+2] = 8'($urandom);
      f6_exp.push_back(ref_resp(f6_words[f*3], f6_words[f*3+1], f6_words[f*3+2], 1'b0));
    end
    Res_Ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          send_word(f6_words[k]);
        end
      end
      begin
        for (int cyc = 0; cyc < 2000 && f6_got.size() < 6; cyc++) begin
          @(posedge CLK);
          #1 Res_Ready = ($urandom_range(0, 2) != 0);
          @(negedge CLK);
          if (Res_Valid && Res_Ready) f6_got.push_back({Res_Err, Res_Data});
        end
      end
    join
    tick();
    check("t6_count", 32'(f6_got.size()), 32'd6);
    for (int k = 0; k < 6 && k < f6_got.size(); k++) begin
      exp = f6_exp[k / 2];
      check($sformatf("t6_word%0d", k), 32'(f6_got[k]),
            (k % 2 == 0) ? 32'({exp[16], exp[7:0]}) : 32'({exp[16], exp[15:8]}));
    end

    // Randomized frames, including silent units, against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op, a, b;
      logic       dead;
      op        = 8'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      dead      = ($urandom_range(0, 7) == 0);
      alu_delay = $urandom_range(0, TMO - 1);
      alu_dead  = dead;
      run_frame($sformatf("rnd%0d_op%02h", i, op), op, a, b, ref_resp(op, a, b, dead),
                $urandom_range(0, 4));
    end
    alu_dead = 1'b0;
    noise_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
